dummy_pattern_gen: RTL and testbench
====================================

DUMMY_PATTERN_GEN -- requirements
Module: dummy_pattern_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of generated data words (8..64).
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of burst length field.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic rising-edge on clk_i.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start_i, input, 1, burst request, sampled only in IDLE.
REQ-006 SHALL have port mode_i, input, 1, pattern select: 0 incrementing counter, 1 LFSR.
REQ-007 SHALL have port seed_i, input, DATA_WIDTH, first word of the burst.
REQ-008 SHALL have port len_i, input, LEN_WIDTH, number of words minus one.
REQ-009 SHALL have ports data_o (output, DATA_WIDTH), valid_o (output, 1) and ready_i (input, 1), a valid/ready stream to the downstream dummy submodule.
REQ-010 SHALL have ports busy_o (output, 1, burst in progress) and done_o (output, 1, one-cycle end-of-burst pulse).

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 SHALL transition IDLE->RUN on start_i=1: latch mode_i, len_i and seed_i; load data_o=seed_i; clear the word counter.
REQ-013 SHALL assert valid_o combinationally equal to (state==RUN), so the first word is valid in the cycle after start_i.
REQ-014 SHALL count a transfer when valid_o && ready_i; data_o and valid_o SHALL hold stable while ready_i=0.
REQ-015 SHALL advance data_o on each transfer: mode 0 data+1 modulo 2^DATA_WIDTH (wraps all-ones->0); mode 1 next LFSR state.
REQ-016 SHALL transition RUN->DONE on the transfer where the word counter equals the latched len; exactly len+1 words SHALL be emitted.
REQ-017 SHALL transition DONE->IDLE unconditionally after one cycle; done_o SHALL be 1 only in DONE.
REQ-018 SHALL drive busy_o=1 in RUN and DONE, and 0 in IDLE.
REQ-019 SHALL ignore start_i in RUN and DONE; no queueing of requests.
REQ-020 SHALL, in mode 1 with seed_i=0, substitute seed 1 so that the LFSR never locks up; data_o SHALL still show 1 as the first word.
REQ-021 SHALL use a maximal-length Galois LFSR, shifting right, for each supported DATA_WIDTH; polynomial constants SHALL come from the package.
REQ-022 SHALL ignore changes to mode_i, len_i and seed_i during a burst.

Reset
REQ-023 SHALL on rst_i=1 enter IDLE and drive data_o=0, valid_o=0, busy_o=0 and done_o=0.
REQ-024 SHALL let reset mid-burst abort immediately without asserting done_o; the next start_i SHALL begin a fresh burst.

Configuration
REQ-025 SHALL, with macro DUMMY_PATTERN_GEN_PARITY_EN defined, add output parity_o (1 bit, even parity of data_o), valid whenever valid_o=1 and 0 in reset.
REQ-026 SHALL, without DUMMY_PATTERN_GEN_PARITY_EN, omit the parity_o port and its logic entirely; all other behaviour SHALL be identical.

Structure
REQ-027 SHALL take the mode enum (MODE_CNT, MODE_LFSR), the FSM state enum and the LFSR tap constants from shared package dummy_pkg.
REQ-028 SHALL instantiate one sub-module, dummy_lfsr: combinational next-state of width DATA_WIDTH, state register kept in the parent.

Verification
REQ-029 SHALL cover: mode 0, seed 0xFFFF_FFFE, len 3, ready_i held 1 -> data FFFF_FFFE, FFFF_FFFF, 0, 1 on consecutive cycles, then done_o pulses for one cycle.
REQ-030 SHALL cover: mode 0, len 0, seed 5 -> exactly one word 5, then busy_o falls two cycles after the transfer.
REQ-031 SHALL cover: ready_i toggling 1,0,0,1 during a burst -> data_o and valid_o stable while stalled, no word skipped or duplicated.
REQ-032 SHALL cover: mode 1, seed 0, len 255 -> first word 1, every word matches the reference-model LFSR sequence, no zero word.
REQ-033 SHALL cover: rst_i asserted on the third word of a len-10 burst -> outputs 0 next cycle, no done_o, and a new start_i produces the full burst.
REQ-034 SHALL cover: with DUMMY_PATTERN_GEN_PARITY_EN, data 0x7 -> parity_o=1; start_i pulsed during RUN -> ignored, word count unchanged.

Source files
------------

// File: rtl/dummy_pkg.sv
// Shared types and LFSR polynomial table for the dummy pattern generator.
package dummy_pkg;

    typedef enum logic {
        MODE_CNT  = 1'b0,
        MODE_LFSR = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned LFSR_MIN_WIDTH = 8;
    localparam int unsigned LFSR_MAX_WIDTH = 64;

    // Single tap position (1-based) as a mask bit.
    function automatic logic [63:0] tap_bit(input int unsigned t);
        return 64'd1 << (t - 1);
    endfunction

    // Galois feedback masks for right-shifting maximal-length LFSRs. Tap
    // positions follow the classic primitive-polynomial table; bit t-1 set
    // for tap t.
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        case (width)
            8:  return tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
            9:  return tap_bit(9)  | tap_bit(5);
            10: return tap_bit(10) | tap_bit(7);
            11: return tap_bit(11) | tap_bit(9);
            12: return tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            13: return tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
            14: return tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
            15: return tap_bit(15) | tap_bit(14);
            16: return tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17: return tap_bit(17) | tap_bit(14);
            18: return tap_bit(18) | tap_bit(11);
            19: return tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            20: return tap_bit(20) | tap_bit(17);
            21: return tap_bit(21) | tap_bit(19);
            22: return tap_bit(22) | tap_bit(21);
            23: return tap_bit(23) | tap_bit(18);
            24: return tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25: return tap_bit(25) | tap_bit(22);
            26: return tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            27: return tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
            28: return tap_bit(28) | tap_bit(25);
            29: return tap_bit(29) | tap_bit(27);
            30: return tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            31: return tap_bit(31) | tap_bit(28);
            32: return tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
            33: return tap_bit(33) | tap_bit(20);
            34: return tap_bit(34) | tap_bit(27) | tap_bit(2)  | tap_bit(1);
            35: return tap_bit(35) | tap_bit(33);
            36: return tap_bit(36) | tap_bit(25);
            37: return tap_bit(37) | tap_bit(5)  | tap_bit(4)  | tap_bit(3) | tap_bit(2)
                       | tap_bit(1);
            38: return tap_bit(38) | tap_bit(6)  | tap_bit(5)  | tap_bit(1);
            39: return tap_bit(39) | tap_bit(35);
            40: return tap_bit(40) | tap_bit(38) | tap_bit(21) | tap_bit(19);
            41: return tap_bit(41) | tap_bit(38);
            42: return tap_bit(42) | tap_bit(41) | tap_bit(20) | tap_bit(19);
            43: return tap_bit(43) | tap_bit(42) | tap_bit(38) | tap_bit(37);
            44: return tap_bit(44) | tap_bit(43) | tap_bit(18) | tap_bit(17);
            45: return tap_bit(45) | tap_bit(44) | tap_bit(42) | tap_bit(41);
            46: return tap_bit(46) | tap_bit(45) | tap_bit(26) | tap_bit(25);
            47: return tap_bit(47) | tap_bit(42);
            48: return tap_bit(48) | tap_bit(47) | tap_bit(21) | tap_bit(20);
            49: return tap_bit(49) | tap_bit(40);
            50: return tap_bit(50) | tap_bit(49) | tap_bit(24) | tap_bit(23);
            51: return tap_bit(51) | tap_bit(50) | tap_bit(36) | tap_bit(35);
            52: return tap_bit(52) | tap_bit(49);
            53: return tap_bit(53) | tap_bit(52) | tap_bit(38) | tap_bit(37);
            54: return tap_bit(54) | tap_bit(53) | tap_bit(18) | tap_bit(17);
            55: return tap_bit(55) | tap_bit(31);
            56: return tap_bit(56) | tap_bit(55) | tap_bit(35) | tap_bit(34);
            57: return tap_bit(57) | tap_bit(50);
            58: return tap_bit(58) | tap_bit(39);
            59: return tap_bit(59) | tap_bit(58) | tap_bit(38) | tap_bit(37);
            60: return tap_bit(60) | tap_bit(59);
            61: return tap_bit(61) | tap_bit(60) | tap_bit(46) | tap_bit(45);
            62: return tap_bit(62) | tap_bit(61) | tap_bit(6)  | tap_bit(5);
            63: return tap_bit(63) | tap_bit(62);
            64: return tap_bit(64) | tap_bit(63) | tap_bit(61) | tap_bit(60);
            default: return 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/dummy_lfsr.sv
// Combinational next-state of a right-shifting Galois LFSR; the state
// register lives in the parent.
module dummy_lfsr
    import dummy_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] cur_state,
    output logic [DATA_WIDTH-1:0] next_state
);

    localparam logic [63:0]           TapsFull = lfsr_taps(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] Taps     = TapsFull[DATA_WIDTH-1:0];

    // Shift right, fold the outgoing bit back through the tap mask.
    always_comb begin
        next_state = cur_state >> 1;
        if (cur_state[0]) begin
            next_state = next_state ^ Taps;
        end
    end

endmodule

// File: rtl/dummy_pattern_gen.sv
// Burst pattern generator: emits len+1 words of an incrementing counter or
// LFSR sequence over a valid/ready stream.
// Optional feature: define DUMMY_PATTERN_GEN_PARITY_EN to add parity_o
// (even parity of data_o).
module dummy_pattern_gen
    import dummy_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o
`ifdef DUMMY_PATTERN_GEN_PARITY_EN
    ,
    output logic                  parity_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] One = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    mode_e                 mode_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] lfsr_next;
    logic [DATA_WIDTH-1:0] seed_eff;
    logic                  xfer;
    logic                  last_word;

    dummy_lfsr #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lfsr (
        .cur_state  (data_q),
        .next_state (lfsr_next)
    );

    // An all-zero LFSR seed would lock up, so it is replaced by 1.
    always_comb begin
        seed_eff = seed_i;
        if (mode_i && (seed_i == '0)) begin
            seed_eff = One;
        end
    end

    // Transfer handshake and end-of-burst detection.
    always_comb begin
        xfer      = valid_o && ready_i;
        last_word = xfer && (cnt_q == len_q);
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state; start_i only matters in idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i)   state_d = StRun;
            StRun:  if (last_word) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs decoded from the current state only.
    always_comb begin
        valid_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            StIdle: ;
            StRun: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
            end
            StDone: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Burst parameters are captured at start and then frozen; data advances
    // only on an accepted word so it holds steady under back-pressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_CNT;
            len_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            if ((state_q == StIdle) && start_i) begin
                mode_q <= mode_e'(mode_i);
                len_q  <= len_i;
                cnt_q  <= '0;
                data_q <= seed_eff;
            end else if (xfer) begin
                cnt_q <= cnt_q + 1'b1;
                if (mode_q == MODE_LFSR) begin
                    data_q <= lfsr_next;
                end else begin
                    data_q <= data_q + One;
                end
            end
        end
    end

    assign data_o = data_q;

`ifdef DUMMY_PATTERN_GEN_PARITY_EN
    // data_q is zero in reset, so parity is zero there too.
    assign parity_o = ^data_q;
`endif

endmodule

// File: tb/tb_dummy_pattern_gen.sv
// Scoreboard bench for dummy_pattern_gen: the driver pushes the expected
// words of each burst, the monitor pops and compares on every transfer.
module tb_dummy_pattern_gen;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;
    // Galois mask for x^32 + x^22 + x^2 + x + 1 (taps 32, 22, 2, 1).
    localparam logic [31:0] POLY32 = 32'h8020_0003;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] seed_in = '0;
    logic [LW-1:0] len_in = '0;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready = 1'b0;
    logic          busy;
    logic          done;
`ifdef DUMMY_PATTERN_GEN_PARITY_EN
    logic          parity;
`endif

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int bursts_done = 0;
    logic [DW-1:0] exp_q[$];

    dummy_pattern_gen #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .mode_i  (mode),
        .seed_i  (seed_in),
        .len_i   (len_in),
        .data_o  (data),
        .valid_o (valid),
        .ready_i (ready),
        .busy_o  (busy),
        .done_o  (done)
`ifdef DUMMY_PATTERN_GEN_PARITY_EN
        ,
        .parity_o (parity)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] w);
        return w[0] ? ((w >> 1) ^ POLY32) : (w >> 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples mid-cycle, away from the active edge.
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [DW-1:0] pd = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("stall_valid", 64'(valid), 64'd1);
                check("stall_data", 64'(data), 64'(pd));
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(data), 64'hDEAD);
                end else begin
`ifdef DUMMY_PATTERN_GEN_PARITY_EN
                    check("parity", 64'(parity), 64'(^exp_q[0]));
`endif
                    check("word", 64'(data), 64'(exp_q.pop_front()));
                end
            end
            if (done) done_cnt++;
            pv = valid;
            pr = ready;
            pd = data;
        end
    end

    // rmode: 0 ready held high, 1 random ready, 2 repeating 1,0,0,1.
    task automatic run_burst(input bit m, input logic [31:0] seed, input logic [7:0] len,
                             input int rmode, input bit poke);
        logic [31:0] w;
        logic [31:0] first;
        int          ncyc;
        bit          seen;
        w = (m && seed == 0) ? 32'd1 : seed;
        first = w;
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back(w);
            w = m ? lfsr_step(w) : w + 32'd1;
        end
        start = 1'b1;
        mode = m;
        seed_in = seed;
        len_in = len;
        ready = 1'b0;
        tick();
        start = 1'b0;
        mode = 1'($urandom);
        seed_in = $urandom;
        len_in = 8'($urandom);
        check("first_valid", 64'(valid), 64'd1);
        check("first_data", 64'(data), 64'(first));
        check("busy_run", 64'(busy), 64'd1);
        ncyc = 0;
        seen = 1'b0;
        while (!seen && ncyc < 4000) begin
            case (rmode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: ready = (ncyc % 4 == 0) || (ncyc % 4 == 3);
            endcase
            start = poke && (ncyc == 2);
            tick();
            ncyc++;
            seen = done;
        end
        start = 1'b0;
        ready = 1'b0;
        check("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            bursts_done++;
            if (rmode == 0) check("burst_cycles", 64'(ncyc), 64'(int'(len) + 1));
            check("queue_drained", 64'(exp_q.size()), 64'd0);
            check("busy_done", 64'(busy), 64'd1);
            check("valid_done", 64'(valid), 64'd0);
            tick();
            check("done_one_cycle", 64'(done), 64'd0);
            check("busy_idle", 64'(busy), 64'd0);
        end
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("rst_data", 64'(data), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        // Counter wrap through all-ones.
        run_burst(1'b0, 32'hFFFF_FFFE, 8'd3, 0, 1'b0);
        // Single-word burst.
        run_burst(1'b0, 32'd5, 8'd0, 0, 1'b0);
        // Stall pattern.
        run_burst(1'b0, $urandom, 8'd7, 2, 1'b0);
        // LFSR from zero seed, full-length burst.
        run_burst(1'b1, 32'd0, 8'd255, 1, 1'b0);
        // Odd-parity word 7.
        run_burst(1'b0, 32'd7, 8'd0, 0, 1'b0);
        // start_i pulsed while running is ignored.
        run_burst(1'b0, $urandom, 8'd10, 0, 1'b1);

        // Reset on the third word of a len-10 burst.
        for (int i = 0; i <= 10; i++) exp_q.push_back(32'd100 + 32'(i));
        start = 1'b1;
        mode = 1'b0;
        seed_in = 32'd100;
        len_in = 8'd10;
        tick();
        start = 1'b0;
        ready = 1'b1;
        tick();
        tick();
        check("third_word", 64'(data), 64'd102);
        rst = 1'b1;
        tick();
        check("abort_data", 64'(data), 64'd0);
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        ready = 1'b0;
        tick();
        check("idle_after_abort", 64'(busy), 64'd0);
        run_burst(1'b0, 32'd100, 8'd10, 0, 1'b0);

        // Random bursts.
        for (int k = 0; k < 10; k++) begin
            run_burst(1'($urandom), $urandom, 8'($urandom_range(0, 30)),
                      int'($urandom_range(0, 2)), 1'b0);
        end

        repeat (3) tick();
        check("done_pulse_count", 64'(done_cnt), 64'(bursts_done));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
